mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
- Shares the single simplified AXI read channel between the icache refill/uncache engine (port 0) and the dcache (port 1).
- Uses the same handshake on every side:
  - requester raises addr_valid with addr and data_len;
  - the memory side answers with one resp_ready pulse;
  - data_len beats of data_valid/data follow.
- Owns grant selection, address latching, beat counting and routing of responses back to the owning requester.

Parameters:
- REQ_NUM, 2, number of requesters; index 0 = icache, 1 = dcache.
- LEN_W, 8, width of data_len and of the beat counter.
- FIXED_PRIO, 1, requester index that wins ties when round-robin is compiled out.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_addr_valid_i  in  REQ_NUM  per-requester address request
- req_addr_i  in  REQ_NUM x 32  per-requester physical address
- req_data_len_i  in  REQ_NUM x LEN_W  per-requester beat count
- req_resp_ready_o  out  REQ_NUM  per-requester address-accepted pulse
- req_data_valid_o  out  REQ_NUM  per-requester data beat valid
- req_data_o  out  32  shared data bus to requesters (meaningful only with req_data_valid_o)
- mem_addr_valid_o  out  1  address request to memory
- mem_addr_o  out  32  latched address
- mem_data_len_o  out  LEN_W  latched beat count
- mem_resp_ready_i  in  1  memory accepted address (1-cycle pulse)
- mem_data_valid_i  in  1  memory data beat valid
- mem_data_i  in  32  memory data beat
- busy_o  out  1  arbiter not in IDLE

Behaviour:
- Reset (async, rst_n=0), all outputs and state take these values immediately:
  - state=IDLE; owner=0; beat_cnt=0;
  - latched addr/len=0; rr pointer=0;
  - all outputs 0.
- State IDLE:
  - if any req_addr_valid_i: pick winner, latch its addr/len into mem_addr_o/mem_data_len_o, record owner, clear beat_cnt, go to ADDR.
  - otherwise stay.
  - Grant latency: request in cycle N, mem_addr_valid_o=1 in cycle N+1.
- State ADDR:
  - mem_addr_valid_o=1 and stays held until mem_resp_ready_i.
  - On mem_resp_ready_i, in the same cycle:
    - req_resp_ready_o[owner]=1 for exactly that cycle; mem_addr_valid_o drops next cycle;
    - if latched len==0 go to IDLE, else go to DATA.
- State DATA:
  - req_data_valid_o[owner]=mem_data_valid_i and req_data_o=mem_data_i, purely combinational (zero-cycle forwarding).
  - Each valid beat increments beat_cnt.
  - When the beat that makes beat_cnt==len is accepted: go to IDLE and clear beat_cnt.
  - mem_data_valid_i outside DATA is ignored and never forwarded.
- Ownership is non-preemptive. A requester dropping addr_valid after grant does not cancel the transaction: it completes and its data is still forwarded.
- New arbitration happens only in IDLE. The cycle after returning to IDLE may grant again, so back-to-back transactions have a 1-cycle IDLE gap.
- Non-owner outputs are 0 at all times.
- busy_o=1 in ADDR and DATA.
- Beat counter is LEN_W wide. len=255 must complete after exactly 255 beats with no wrap before the compare.
- Assertion-checked errors (bench flags these):
  - mem_resp_ready_i in IDLE or DATA;
  - mem_data_valid_i after the final beat.
- States are encoded in a typedef enum; unreachable encodings go to IDLE.

Optional Feature:
- Macro: MEM_RD_ARB_RR_EN
- Defined: round-robin arbitration.
  - A 1-bit-per-requester pointer marks the last winner.
  - When both requesters are valid in IDLE, the one not granted last wins.
  - The pointer updates only on grant.
- Undefined: fixed priority. Requester FIXED_PRIO wins when both are valid; no pointer register exists.

Test Plan:
- Single icache request: addr=0x1C000020, len=8, valid cycle 0 → mem_addr_valid_o=1 from cycle 1 with addr 0x1C000020/len 8. resp at cycle 3 → req_resp_ready_o=2'b01 that cycle. 8 beats 0xA0..0xA7 forwarded on req_data_valid_o[0] only; busy_o falls after the 8th beat.
- Simultaneous requests, both valid at cycle 0, icache len=2, dcache len=4:
  - fixed priority (FIXED_PRIO=1): dcache served first, icache granted in the IDLE cycle after the dcache's 4th beat;
  - MEM_RD_ARB_RR_EN defined: alternates winners across three repeated contended rounds (1,0,1 starting from pointer 0).
- Zero-length: dcache len=0 → resp pulse, return to IDLE next cycle, no data_valid forwarded, busy_o low two cycles after grant.
- Requester withdraws: icache drops addr_valid in ADDR before resp → transaction still completes; 2 beats delivered to port 0.
- Async reset mid-DATA after 3 of 8 beats: rst_n low mid-cycle → all outputs 0 immediately, state IDLE. A fresh request after reset completes normally with beat_cnt starting at 0.
- Max length: len=255 with data_valid gaps every other cycle → exactly 255 forwarded beats, then IDLE.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Two-requester read-channel arbiter: grant, latch addr/len, count beats, route responses to the owner.
// Latency: request seen in IDLE -> mem_addr_valid_o next cycle; data beats forwarded combinationally.
// Backpressure: address held until mem_resp_ready_i; one grant at a time; MEM_RD_ARB_RR_EN selects round-robin.
module mem_rd_arbiter #(
    parameter int REQ_NUM    = 2,
    parameter int LEN_W      = 8,
    parameter int FIXED_PRIO = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_NUM-1:0]              req_addr_valid_i,
    input  logic [REQ_NUM-1:0][31:0]        req_addr_i,
    input  logic [REQ_NUM-1:0][LEN_W-1:0]   req_data_len_i,
    output logic [REQ_NUM-1:0]              req_resp_ready_o,
    output logic [REQ_NUM-1:0]              req_data_valid_o,
    output logic [31:0]                     req_data_o,
    output logic                            mem_addr_valid_o,
    output logic [31:0]                     mem_addr_o,
    output logic [LEN_W-1:0]                mem_data_len_o,
    input  logic                            mem_resp_ready_i,
    input  logic                            mem_data_valid_i,
    input  logic [31:0]                     mem_data_i,
    output logic                            busy_o
);

    localparam int OW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      addr_q, addr_d;
    logic [OW-1:0]    win;
    logic [LEN_W:0]   cnt_inc;

    // One extra bit so len=255 compares against 255 without wrapping.
    assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

`ifdef MEM_RD_ARB_RR_EN
    logic [REQ_NUM-1:0] rr_q, rr_d;

    always_comb begin
        int last_idx;
        int idx;
        last_idx = 0;
        idx      = 0;
        win      = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (rr_q[i]) last_idx = i;
        end
        // Walk from farthest to nearest after the last winner; the nearest valid one sticks.
        for (int i = REQ_NUM; i >= 1; i--) begin
            idx = last_idx + i;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            if (req_addr_valid_i[idx]) win = OW'(idx);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && |req_addr_valid_i) begin
            rr_d      = '0;
            rr_d[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`else
    always_comb begin
        win = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_addr_valid_i[i]) win = OW'(i);
        end
        if (req_addr_valid_i[FIXED_PRIO]) win = OW'(FIXED_PRIO);
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (|req_addr_valid_i) begin
                    owner_d = win;
                    addr_d  = req_addr_i[win];
                    len_d   = req_data_len_i[win];
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mem_resp_ready_i) state_d = (len_q == '0) ? IDLE : DATA;
            end
            DATA: begin
                if (mem_data_valid_i) begin
                    if (cnt_inc == {1'b0, len_q}) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc[LEN_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign mem_addr_valid_o = (state_q == ADDR);
    assign mem_addr_o       = addr_q;
    assign mem_data_len_o   = len_q;

    always_comb begin
        req_resp_ready_o = '0;
        req_data_valid_o = '0;
        req_data_o       = '0;
        if (state_q == ADDR && mem_resp_ready_i) req_resp_ready_o[owner_q] = 1'b1;
        if (state_q == DATA && mem_data_valid_i) begin
            req_data_valid_o[owner_q] = 1'b1;
            req_data_o                = mem_data_i;
        end
    end

    a_resp_only_in_addr: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp_ready_i |-> state_q == ADDR);
    a_data_only_in_data: assert property (@(posedge clk) disable iff (!rst_n)
        mem_data_valid_i |-> state_q == DATA);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
module tb_mem_rd_arbiter;

    localparam int FIXED_PRIO = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_addr_valid_i;
    logic [1:0][31:0] req_addr_i;
    logic [1:0][7:0]  req_data_len_i;
    logic [1:0]       req_resp_ready_o;
    logic [1:0]       req_data_valid_o;
    logic [31:0]      req_data_o;
    logic             mem_addr_valid_o;
    logic [31:0]      mem_addr_o;
    logic [7:0]       mem_data_len_o;
    logic             mem_resp_ready_i;
    logic             mem_data_valid_i;
    logic [31:0]      mem_data_i;
    logic             busy_o;

    int n_chk  = 0;
    int n_pass = 0;
    int last_w = -1;

    always #5 clk = ~clk;

    mem_rd_arbiter #(.REQ_NUM(2), .LEN_W(8), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_addr_valid_i (req_addr_valid_i),
        .req_addr_i       (req_addr_i),
        .req_data_len_i   (req_data_len_i),
        .req_resp_ready_o (req_resp_ready_o),
        .req_data_valid_o (req_data_valid_o),
        .req_data_o       (req_data_o),
        .mem_addr_valid_o (mem_addr_valid_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_len_o   (mem_data_len_o),
        .mem_resp_ready_i (mem_resp_ready_i),
        .mem_data_valid_i (mem_data_valid_i),
        .mem_data_i       (mem_data_i),
        .busy_o           (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Arbitration rule: a lone requester wins; on a tie either the fixed-priority
    // index or the requester that was not granted most recently.
    function automatic int pick(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef MEM_RD_ARB_RR_EN
        return (last_w == 1) ? 0 : 1;
`else
        return FIXED_PRIO;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_avld"},  mem_addr_valid_o, 0);
        check({tag, "_addr"},  mem_addr_o, 0);
        check({tag, "_len"},   mem_data_len_o, 0);
        check({tag, "_resp"},  req_resp_ready_o, 0);
        check({tag, "_dvld"},  req_data_valid_o, 0);
        check({tag, "_dat"},   req_data_o, 0);
    endtask

    // Entered and left just after a rising edge. resp_dly/gap of -1 mean random.
    task automatic run_round(input logic [1:0] vm, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [7:0] l0, input logic [7:0] l1, input bit drop,
                             input int resp_dly, input int gap, input logic [31:0] seq_base);
        logic [1:0]  p_vld;
        logic [31:0] p_addr [2];
        logic [7:0]  p_len  [2];
        logic [1:0]  oh;
        logic [31:0] dat;
        int w, d, g;
        p_vld = vm;
        p_addr[0] = a0; p_addr[1] = a1;
        p_len[0]  = l0; p_len[1]  = l1;
        req_addr_i[0] = a0; req_addr_i[1] = a1;
        req_data_len_i[0] = l0; req_data_len_i[1] = l1;
        req_addr_valid_i = vm;
        while (p_vld != 2'b00) begin
            @(negedge clk);
            check("idle_busy", busy_o, 0);
            check("idle_avld", mem_addr_valid_o, 0);
            check("idle_dvld", req_data_valid_o, 0);
            w = pick(p_vld);
            last_w = w;
            oh = 2'b01 << w;
            @(posedge clk); #1;
            // Requester inputs may change freely once granted; the DUT must hold its latched copy.
            req_addr_i[w] = $urandom;
            req_data_len_i[w] = 8'($urandom);
            if (drop) req_addr_valid_i[w] = 1'b0;
            d = (resp_dly < 0) ? $urandom_range(0, 3) : resp_dly;
            for (int i = 0; i <= d; i++) begin
                mem_resp_ready_i = (i == d);
                @(negedge clk);
                check("addr_vld",  mem_addr_valid_o, 1);
                check("addr_val",  mem_addr_o, p_addr[w]);
                check("addr_len",  mem_data_len_o, p_len[w]);
                check("addr_busy", busy_o, 1);
                check("addr_resp", req_resp_ready_o, (i == d) ? oh : 2'b00);
                @(posedge clk); #1;
            end
            mem_resp_ready_i = 1'b0;
            req_addr_valid_i[w] = 1'b0;
            p_vld[w] = 1'b0;
            for (int k = 0; k < int'(p_len[w]); k++) begin
                g = (gap < 0) ? $urandom_range(0, 2) : gap;
                repeat (g) begin
                    mem_data_valid_i = 1'b0;
                    @(negedge clk);
                    check("gap_dvld", req_data_valid_o, 0);
                    check("gap_busy", busy_o, 1);
                    @(posedge clk); #1;
                end
                dat = (seq_base != 0) ? seq_base + k : $urandom;
                mem_data_valid_i = 1'b1;
                mem_data_i = dat;
                @(negedge clk);
                check("beat_dvld", req_data_valid_o, oh);
                check("beat_dat",  req_data_o, dat);
                check("beat_avld", mem_addr_valid_o, 0);
                @(posedge clk); #1;
            end
            mem_data_valid_i = 1'b0;
        end
        @(negedge clk);
        check("done_busy", busy_o, 0);
        check("done_dvld", req_data_valid_o, 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_data();
        req_addr_valid_i = 2'b01;
        req_addr_i[0] = 32'h1C00_0100;
        req_data_len_i[0] = 8'd8;
        @(posedge clk); #1;
        req_addr_valid_i = 2'b00;
        mem_resp_ready_i = 1'b1;
        @(negedge clk);
        check("rst_pre_resp", req_resp_ready_o, 2'b01);
        @(posedge clk); #1;
        mem_resp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_data_valid_i = 1'b1;
            mem_data_i = $urandom;
            @(posedge clk); #1;
        end
        mem_data_valid_i = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_pre_busy", busy_o, 1);
        check("rst_pre_dvld", req_data_valid_o, 2'b01);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        mem_data_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_w = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_addr_valid_i = '0;
        req_addr_i = '0;
        req_data_len_i = '0;
        mem_resp_ready_i = 1'b0;
        mem_data_valid_i = 1'b0;
        mem_data_i = '0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_round(2'b01, 32'h1C00_0020, 32'h0, 8'd8, 8'd0, 1'b0, 2, 0, 32'hA0);
        for (int r = 0; r < 3; r++)
            run_round(2'b11, $urandom, $urandom, 8'd2, 8'd4, 1'b0, -1, -1, 0);
        run_round(2'b10, 32'h0, 32'h8000_0040, 8'd0, 8'd0, 1'b0, 0, 0, 0);
        run_round(2'b01, 32'h1C00_0200, 32'h0, 8'd2, 8'd0, 1'b1, 2, 0, 0);
        reset_mid_data();
        run_round(2'b01, 32'h1C00_0300, 32'h0, 8'd3, 8'd0, 1'b0, 1, 0, 0);
        run_round(2'b10, 32'h0, 32'h8000_1000, 8'd0, 8'd255, 1'b0, 1, 1, 0);
        for (int r = 0; r < 40; r++)
            run_round(2'($urandom_range(1, 3)), $urandom, $urandom,
                      8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                      1'($urandom_range(0, 1)), -1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
